// File: rtl/compare_pipe.sv
// Two-stage pipelined compare / min-max / running-min unit; result is registered one edge after operand capture.
// Backpressure: stages and accumulator freeze while out_valid && !out_ready, and in_ready follows the advance condition.
module compare_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   op,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [2:0]   flags,
  output logic         acc_valid
);

  localparam logic [2:0] OP_CMP_S     = 3'd0;
  localparam logic [2:0] OP_CMP_U     = 3'd1;
  localparam logic [2:0] OP_MIN_S     = 3'd2;
  localparam logic [2:0] OP_MAX_S     = 3'd3;
  localparam logic [2:0] OP_MIN_U     = 3'd4;
  localparam logic [2:0] OP_MAX_U     = 3'd5;
  localparam logic [2:0] OP_ACC_MIN_S = 3'd6;
  localparam logic [2:0] OP_ACC_CLR   = 3'd7;

  typedef struct packed {
    logic [2:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
  } s1_t;

  s1_t          s1_dat;
  logic         s1_vld;
  logic [N-1:0] acc;
  logic         advance;

  logic [N-1:0] rhs;
  logic         sgn;
  logic         gt;
  logic         eq;
  logic         lt;
  logic [N-1:0] nxt_res;
  logic [2:0]   nxt_flags;
  logic [N-1:0] nxt_acc;
  logic         nxt_acc_vld;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  // Direct relational compares on $signed operands stay exact at the extremes,
  // unlike a subtract-and-test-sign approach.
  always_comb begin
    rhs = (s1_dat.op == OP_ACC_MIN_S) ? acc : s1_dat.b;
    sgn = (s1_dat.op == OP_CMP_S) || (s1_dat.op == OP_MIN_S) ||
          (s1_dat.op == OP_MAX_S) || (s1_dat.op == OP_ACC_MIN_S);
    gt  = sgn ? ($signed(s1_dat.a) > $signed(rhs)) : (s1_dat.a > rhs);
    lt  = sgn ? ($signed(s1_dat.a) < $signed(rhs)) : (s1_dat.a < rhs);
    eq  = (s1_dat.a == rhs);

    nxt_res     = s1_dat.a;
    nxt_flags   = {gt, eq, lt};
    nxt_acc     = acc;
    nxt_acc_vld = acc_valid;

    case (s1_dat.op)
      OP_CMP_S, OP_CMP_U: nxt_res = gt ? N'(1) : (lt ? '1 : '0);
      OP_MIN_S, OP_MIN_U: nxt_res = gt ? rhs : s1_dat.a;
      OP_MAX_S, OP_MAX_U: nxt_res = lt ? rhs : s1_dat.a;
      OP_ACC_MIN_S: begin
        if (!acc_valid) begin
          nxt_acc   = s1_dat.a;
          nxt_flags = 3'b010;
        end else begin
          nxt_acc   = lt ? s1_dat.a : acc;
        end
        nxt_acc_vld = 1'b1;
        nxt_res     = nxt_acc;
      end
      OP_ACC_CLR: begin
        nxt_acc     = '0;
        nxt_acc_vld = 1'b0;
        nxt_res     = '0;
        nxt_flags   = 3'b000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_dat    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= 3'b000;
      acc       <= '0;
      acc_valid <= 1'b0;
    end else if (advance) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_dat.op <= op;
        s1_dat.a  <= A;
        s1_dat.b  <= B;
      end
      out_valid <= s1_vld;
      // Accumulator moves with the output register so acc_valid lines up with its result.
      if (s1_vld) begin
        result    <= nxt_res;
        flags     <= nxt_flags;
        acc       <= nxt_acc;
        acc_valid <= nxt_acc_vld;
      end
    end
  end

endmodule

// File: tb/tb_compare_pipe.sv
// Directed plus random bench for compare_pipe at N=8 and N=16, scoreboard-checked.
module tb_compare_pipe;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flg;
    logic        accv;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid_8 = 1'b0, in_ready_8, out_valid_8, out_ready_8 = 1'b1, acc_valid_8;
  logic [2:0]  op_8 = 3'd0, flags_8;
  logic [7:0]  a_8 = 8'd0, b_8 = 8'd0, result_8;

  logic        in_valid_16 = 1'b0, in_ready_16, out_valid_16, out_ready_16 = 1'b1, acc_valid_16;
  logic [2:0]  op_16 = 3'd0, flags_16;
  logic [15:0] a_16 = 16'd0, b_16 = 16'd0, result_16;

  compare_pipe #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid_8), .in_ready(in_ready_8), .op(op_8),
    .A(a_8), .B(b_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .flags(flags_8), .acc_valid(acc_valid_8)
  );

  compare_pipe #(.N(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid_16), .in_ready(in_ready_16), .op(op_16),
    .A(a_16), .B(b_16), .out_valid(out_valid_16), .out_ready(out_ready_16),
    .result(result_16), .flags(flags_16), .acc_valid(acc_valid_16)
  );

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int n8 = 0, n16 = 0;
  logic cap8, cap16;
  logic lat_chk = 1'b0;
  logic use_dir = 1'b0;
  logic [31:0] dir_res;
  logic [2:0]  dir_flg;
  exp_t q8[$];
  exp_t q16[$];
  logic [31:0] m_acc8 = 0, m_acc16 = 0;
  logic        m_accv8 = 0, m_accv16 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [31:0] v, input int w);
    return v[w-1] ? longint'(v) - (longint'(1) << w) : longint'(v);
  endfunction

  // Reference model, evaluated in capture order.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int w, inout logic [31:0] acc, inout logic accv,
                       output logic [31:0] res, output logic [2:0] flg);
    longint ca, cb, mask;
    logic [31:0] rhs;
    logic sgn;
    mask = (longint'(1) << w) - 1;
    sgn  = (op == 3'd0) || (op == 3'd2) || (op == 3'd3) || (op == 3'd6);
    rhs  = (op == 3'd6) ? acc : b;
    ca   = sgn ? sx(a, w) : longint'(a);
    cb   = sgn ? sx(rhs, w) : longint'(rhs);
    flg  = {ca > cb, ca == cb, ca < cb};
    res  = 32'd0;
    case (op)
      3'd0, 3'd1: res = (ca > cb) ? 32'd1 : ((ca < cb) ? 32'(mask) : 32'd0);
      3'd2, 3'd4: res = (cb < ca) ? rhs : a;
      3'd3, 3'd5: res = (cb > ca) ? rhs : a;
      3'd6: begin
        if (!accv) begin
          acc  = a;
          accv = 1'b1;
          flg  = 3'b010;
        end else if (ca < cb) begin
          acc = a;
        end
        res = acc;
      end
      default: begin
        acc  = 32'd0;
        accv = 1'b0;
        res  = 32'd0;
        flg  = 3'b000;
      end
    endcase
  endtask

  // One cycle: observe handshakes away from the edge, then move to the next negedge.
  task automatic cyc();
    exp_t e;
    logic [31:0] r;
    logic [2:0]  f;
    #1;
    cap8  = 1'b0;
    cap16 = 1'b0;
    if (!rst) begin
      if (out_valid_8 && out_ready_8) begin
        chk("q8_nonempty", 32'(q8.size() != 0), 32'd1);
        if (q8.size() != 0) begin
          e = q8.pop_front();
          chk("result8", 32'(result_8), e.res);
          chk("flags8", 32'(flags_8), 32'(e.flg));
          chk("acc_valid8", 32'(acc_valid_8), 32'(e.accv));
          if (lat_chk) chk("latency8", 32'(cycle - e.cyc), 32'd2);
        end
      end
      if (out_valid_16 && out_ready_16) begin
        chk("q16_nonempty", 32'(q16.size() != 0), 32'd1);
        if (q16.size() != 0) begin
          e = q16.pop_front();
          chk("result16", 32'(result_16), e.res);
          chk("flags16", 32'(flags_16), 32'(e.flg));
          chk("acc_valid16", 32'(acc_valid_16), 32'(e.accv));
        end
      end
      if (in_valid_8 && in_ready_8) begin
        model(op_8, 32'(a_8), 32'(b_8), 8, m_acc8, m_accv8, r, f);
        e.res  = use_dir ? dir_res : r;
        e.flg  = use_dir ? dir_flg : f;
        e.accv = m_accv8;
        e.cyc  = cycle;
        q8.push_back(e);
        cap8 = 1'b1;
        n8++;
      end
      if (in_valid_16 && in_ready_16) begin
        model(op_16, 32'(a_16), 32'(b_16), 16, m_acc16, m_accv16, r, f);
        e.res  = r;
        e.flg  = f;
        e.accv = m_accv16;
        e.cyc  = cycle;
        q16.push_back(e);
        cap16 = 1'b1;
        n16++;
      end
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic send8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] xr, input logic [2:0] xf);
    op_8 = o; a_8 = a; b_8 = b; in_valid_8 = 1'b1;
    dir_res = 32'(xr); dir_flg = xf;
    cap8 = 1'b0;
    for (int t = 0; t < 50 && !cap8; t++) cyc();
    chk("send8_accepted", 32'(cap8), 32'd1);
  endtask

  task automatic drain();
    in_valid_8 = 1'b0; in_valid_16 = 1'b0;
    out_ready_8 = 1'b1; out_ready_16 = 1'b1;
    for (int t = 0; t < 40 && (q8.size() != 0 || q16.size() != 0); t++) cyc();
    cyc();
    chk("drain_q8_empty", 32'(q8.size()), 32'd0);
    chk("drain_q16_empty", 32'(q16.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] hold_res;
    logic [2:0] hold_flg;

    // Reset state
    repeat (2) cyc();
    chk("in_ready_in_reset", 32'(in_ready_8), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready_8), 32'd1);
    chk("rst_out_valid", 32'(out_valid_8), 32'd0);
    chk("rst_result", 32'(result_8), 32'd0);
    chk("rst_flags", 32'(flags_8), 32'd0);
    chk("rst_acc_valid", 32'(acc_valid_8), 32'd0);

    // Signed compares, back to back, with latency tracking
    use_dir = 1'b1;
    lat_chk = 1'b1;
    send8(3'd0,  8'sd6,  8'sd8, 8'hFF, 3'b001);
    send8(3'd0,  8'sd8,  8'sd6, 8'h01, 3'b100);
    send8(3'd0, -8'sd6,  8'sd8, 8'hFF, 3'b001);
    send8(3'd0,  8'sd6, -8'sd8, 8'h01, 3'b100);
    send8(3'd0, -8'sd6, -8'sd8, 8'h01, 3'b100);
    send8(3'd0, -8'sd8, -8'sd6, 8'hFF, 3'b001);
    drain();
    lat_chk = 1'b0;

    // Unsigned / min / max and extremes
    send8(3'd1, 8'hFA, 8'h08, 8'h01, 3'b100);
    send8(3'd4, 8'hFA, 8'h08, 8'h08, 3'b100);
    send8(3'd3, 8'h80, 8'h7F, 8'h7F, 3'b001);
    send8(3'd2, 8'h05, 8'h05, 8'h05, 3'b010);
    send8(3'd5, 8'h80, 8'h7F, 8'h80, 3'b100);
    drain();

    // Running minimum
    send8(3'd7, 8'h00, 8'h00, 8'h00, 3'b000);
    send8(3'd6, 8'sd10,  8'h00, 8'h0A, 3'b010);
    send8(3'd6, 8'sd3,   8'h00, 8'h03, 3'b001);
    send8(3'd6, 8'sd7,   8'h00, 8'h03, 3'b100);
    send8(3'd6, -8'sd4,  8'h00, 8'hFC, 3'b001);
    send8(3'd6, 8'h80,   8'h00, 8'h80, 3'b001);
    send8(3'd7, 8'h00, 8'h00, 8'h00, 3'b000);
    drain();

    // Backpressure: stall with the first result held at the output
    send8(3'd0, 8'sd1, 8'sd2, 8'hFF, 3'b001);
    send8(3'd0, 8'sd2, 8'sd1, 8'h01, 3'b100);
    op_8 = 3'd0; a_8 = 8'sd3; b_8 = 8'sd3; dir_res = 32'h00; dir_flg = 3'b010;
    out_ready_8 = 1'b0;
    #1;
    chk("stall_out_valid", 32'(out_valid_8), 32'd1);
    hold_res = result_8;
    hold_flg = flags_8;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready_8), 32'd0);
      chk("stall_result", 32'(result_8), 32'(hold_res));
      chk("stall_flags", 32'(flags_8), 32'(hold_flg));
      cyc();
    end
    out_ready_8 = 1'b1;
    send8(3'd0, 8'sd3, 8'sd3, 8'h00, 3'b010);
    send8(3'd0, -8'sd1, 8'sd1, 8'hFF, 3'b001);
    drain();

    // Reset with two ops in flight and acc=3
    send8(3'd7, 8'h00, 8'h00, 8'h00, 3'b000);
    send8(3'd6, 8'sd3, 8'h00, 8'h03, 3'b010);
    drain();
    send8(3'd0, 8'sd1, 8'sd2, 8'hFF, 3'b001);
    send8(3'd0, 8'sd2, 8'sd1, 8'h01, 3'b100);
    in_valid_8 = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready_8), 32'd0);
    cyc();
    rst = 1'b0;
    q8.delete();
    q16.delete();
    m_acc8 = 0; m_accv8 = 1'b0; m_acc16 = 0; m_accv16 = 1'b0;
    chk("midrst_out_valid", 32'(out_valid_8), 32'd0);
    chk("midrst_acc_valid", 32'(acc_valid_8), 32'd0);
    chk("midrst_flags", 32'(flags_8), 32'd0);
    send8(3'd6, 8'sd50, 8'h00, 8'h32, 3'b010);
    drain();

    // Random traffic on both widths
    use_dir = 1'b0;
    n8 = 0; n16 = 0;
    for (int i = 0; i < 60000 && (n8 < 10000 || n16 < 10000); i++) begin
      in_valid_8   = ($urandom_range(0, 9) < 7);
      op_8         = 3'($urandom_range(0, 7));
      a_8          = 8'($urandom);
      b_8          = 8'($urandom);
      out_ready_8  = ($urandom_range(0, 9) < 7);
      in_valid_16  = ($urandom_range(0, 9) < 7);
      op_16        = 3'($urandom_range(0, 7));
      a_16         = 16'($urandom);
      b_16         = 16'($urandom);
      out_ready_16 = ($urandom_range(0, 9) < 7);
      cyc();
    end
    chk("rand_ops8", 32'(n8 >= 10000), 32'd1);
    chk("rand_ops16", 32'(n16 >= 10000), 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/compare_pipe.md
Name: compare_pipe

Overview:
- Parametrised, pipelined successor to the combinational `compare` unit in the exe_unit_1 datapath.
- Accepts an operand pair and an opcode through a valid/ready handshake.
- Offers signed/unsigned compare, min/max select and a running-minimum accumulator.
- Returns an N-bit result plus gt/eq/lt flags, 2 cycles later, with full output backpressure.

Parameters:
- N, 8: operand/result width in bits; legal values ≥ 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand/op presented.
- in_ready  out  1  block can accept this cycle.
- op  in  3  operation select (see Behaviour).
- A  in  N  operand A.
- B  in  N  operand B (ignored by ACC ops).
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  N  operation result.
- flags  out  3  {gt, eq, lt} of the A-vs-B (or A-vs-acc) comparison.
- acc_valid  out  1  accumulator holds a value.

Behaviour:
- Reset: synchronous, active-high; clk and rst as above.
  - On a rising edge with rst=1: out_valid=0, result=0, flags=3'b000, acc=0, acc_valid=0, stage-1 valid=0.
  - Reset mid-operation discards all in-flight items. The accumulator is lost.
  - in_ready is 0 while rst=1.
- Pipeline:
  - Stage 1 registers {op, A, B}.
  - Stage 2 computes from stage 1 and registers result/flags into the output.
- Advance rule: advance = !out_valid || out_ready. in_ready = advance && !rst.
  - Input is captured when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
- Latency: 2 cycles, capture edge to out_valid, when out_ready is held 1. Throughput is 1/cycle.
- Stall: when out_valid=1 and out_ready=0:
  - both stages and the accumulator freeze;
  - result and flags stay stable;
  - in_ready=0.
- Bubbles: empty stage-1 slots propagate as out_valid=0 on advance.
- Simultaneous consume and capture in the same cycle is legal and loses nothing.
- Opcodes (s = signed two's-complement, u = unsigned):
  - 000 CMP_S: result = 1 if A>B, 0 if A==B, all-ones (-1) if A<B.
  - 001 CMP_U: same encoding, unsigned compare.
  - 010 MIN_S: result = signed min(A,B).
  - 011 MAX_S: result = signed max(A,B).
  - 100 MIN_U: result = unsigned min(A,B).
  - 101 MAX_U: result = unsigned max(A,B).
  - 110 ACC_MIN_S:
    - if acc_valid=0: acc←A, acc_valid←1, flags=3'b010 (eq).
    - else: acc←signed min(acc,A), flags from A vs old acc.
    - result = new acc value in both cases.
  - 111 ACC_CLR: acc←0, acc_valid←0, result=0, flags=3'b000.
- Flags:
  - Exactly one of gt/eq/lt is set for ops 000–110.
  - Ops 000/010/011 use signed compare; ops 001/100/101 use unsigned compare.
- Accumulator timing:
  - Updates only on the stage-1→2 advance of an ACC op.
  - Back-to-back ACC ops see each predecessor's update (no hazard).
  - acc_valid changes on the same edge that the ACC result enters the output.
- Edge values:
  - Compares of most-negative versus most-positive are exact; no overflow via subtraction.
  - A==B min/max returns A.

Test Plan:
1. N=8, out_ready=1, sequence CMP_S (6,8), (8,6), (-6,8), (6,-8), (-6,-8), (-8,-6):
   - results -1, 1, -1, 1, 1, -1;
   - flags lt, gt, lt, gt, gt, lt;
   - each appears 2 cycles after capture, one per cycle.
2. CMP_U (-6=0xFA, 8) → result 1, gt. MIN_U (0xFA, 8) → 8. MAX_S (-128, 127) → 127. MIN_S (5, 5) → 5, eq.
3. ACC_CLR, then ACC_MIN_S with A = 10, 3, 7, -4, -128:
   - results 10, 3, 3, -4, -128;
   - acc_valid rises with the first result.
   - Then ACC_CLR → result 0, acc_valid=0.
4. Backpressure:
   - Stream 4 CMP_S ops; hold out_ready=0 for 5 cycles after the first out_valid.
   - Required: result/flags stable, in_ready=0 throughout.
   - After release, all 4 results arrive in order with no loss or duplication.
5. Reset mid-stream:
   - Assert rst for 1 cycle with 2 ops in flight and acc=3.
   - Next cycle: out_valid=0, acc_valid=0, flags=0.
   - First post-reset ACC_MIN_S A=50 → result 50.
6. Random: 10k ops, random in_valid/out_ready, N=8 and N=16, checked against a reference scoreboard.
